relu_array_pipe: RTL
====================

// Module: relu_array_pipe
// PURPOSE
//  Multi-channel, mode-selectable activation stage for the accelerator datapath.
//  Takes CHANNELS signed lanes per beat and applies one of four activations:
//  bypass, ReLU, clamped ReLU (ReLU6) or leaky ReLU.
//  Two-stage registered pipeline with valid/ready handshake on both sides.
//  Sits between the conv accumulator/requant output and the feature-map writeback.
// PARAMETERS
//  BITWIDTH    8  lane width, signed two's complement
//  CHANNELS    4  lanes processed per beat
//  MAX_VAL     6  clamp ceiling for mode 2; must satisfy 0 < MAX_VAL <= 2^(BITWIDTH-1)-1
//  LEAKY_SHIFT 3  arithmetic right shift applied to negative lanes in mode 3
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  synchronous reset, active-high
//  mode       in   2                  activation select, sampled with in_data
//  in_valid   in   1                  input beat valid
//  in_ready   out  1                  input beat accepted when in_valid & in_ready
//  in_data    in   CHANNELS*BITWIDTH  lane k at [k*BITWIDTH +: BITWIDTH]
//  out_valid  out  1                  output beat valid
//  out_ready  in   1                  downstream accepts when out_valid & out_ready
//  out_data   out  CHANNELS*BITWIDTH  lane-aligned with in_data
//  busy       out  1                  any pipeline stage holds a beat
// BEHAVIOUR
//  Reset: s1_valid = s2_valid = 0; out_valid = 0; out_data = 0; busy = 0; in_ready = 1 from the first cycle after reset.
//  Stage 1 (S1): registers in_data and mode on input handshake.
//  Stage 2 (S2): registers the activation result computed from S1.
//  adv2 = s1_valid & (!s2_valid | out_ready).
//  in_ready = !s1_valid | adv2. This is a combinational path from out_ready to in_ready.
//  Latency: 2 cycles from input handshake to out_valid when no stall.
//  Throughput: 1 beat/cycle. No beat is dropped or duplicated; output order equals input order.
//  out_data and out_valid hold stable while out_valid & !out_ready.
//  Max 2 beats in flight. With out_ready held low, in_ready falls once S1 and S2 are both full.
//  Simultaneous accept and drain in the same cycle is legal at full rate.
//  Per lane x (signed):
//   mode 0 bypass : y = x
//   mode 1 ReLU   : y = (x < 0) ? 0 : x
//   mode 2 ReLU6  : y = (x < 0) ? 0 : (x > MAX_VAL) ? MAX_VAL : x
//   mode 3 leaky  : y = (x < 0) ? (x >>> LEAKY_SHIFT) : x   (floor rounding; -1 stays -1)
//  All comparisons are signed, so the most negative value (-2^(BITWIDTH-1)) is negative.
//  Results are always representable; no overflow is possible.
//  Mode is captured per beat, so a mode change between beats affects only later beats.
//  rst asserted mid-stream:
//   - both stages are flushed next cycle and in-flight beats are discarded;
//   - in_valid is ignored while rst = 1.
//  busy = s1_valid | s2_valid.
// CONFIGURATION
//  RELU_CLIP_CNT_EN defined:
//   - adds ports clip_clr (in, 1) and clip_cnt (out, 16).
//   - On each output handshake, clip_cnt += number of mode-2 lanes whose input was > MAX_VAL.
//   - clip_cnt saturates at 16'hFFFF.
//   - clip_clr = 1 zeroes clip_cnt on the next edge; clear wins over a same-cycle increment.
//   - rst zeroes clip_cnt. Clip flags are carried in S2 alongside the data.
//  RELU_CLIP_CNT_EN undefined: ports and counter logic are absent; datapath is identical.
// TESTING (BITWIDTH=8, CHANNELS=4, MAX_VAL=6, LEAKY_SHIFT=3; lanes listed lane0..lane3)
//  1. mode1, {-5,0,3,127}, out_ready=1 -> {0,0,3,127} with out_valid exactly 2 cycles after accept.
//  2. mode2, {-1,5,6,100} -> {0,5,6,6}. With RELU_CLIP_CNT_EN, clip_cnt 0 -> 1 (lane3 only).
//  3. mode3, {-8,-1,-128,9} -> {-1,-1,-16,9}. Mode0, {-128,-1,0,127} -> unchanged.
//  4. 6 back-to-back beats, out_ready low cycles 2..6 ->
//     in_ready low after 2 beats held; out_data stable while stalled;
//     all 6 beats emerge in order, none lost or duplicated.
//  5. rst pulsed 1 cycle with S1 and S2 full ->
//     next cycle out_valid=0, busy=0, in_ready=1; the flushed beats never appear.
//  6. Mode alternates 1,2,3,0 per beat on constant {-16,8,-16,8} ->
//     outputs {0,8,0,8}, {0,6,0,6}, {-2,8,-2,8}, {-16,8,-16,8} at 1 beat/cycle.

Source files
------------

// File: rtl/relu_array_pipe.sv
// relu_array_pipe: two-stage valid/ready activation pipeline (bypass / ReLU / ReLU6 / leaky ReLU).
// Defining RELU_CLIP_CNT_EN adds clip_clr/clip_cnt and a saturating count of ReLU6 clipped lanes.
module relu_array_pipe #(
    parameter int BITWIDTH    = 8,
    parameter int CHANNELS    = 4,
    parameter int MAX_VAL     = 6,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*BITWIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*BITWIDTH-1:0] out_data,
`ifdef RELU_CLIP_CNT_EN
    input  logic                         clip_clr,
    output logic [15:0]                  clip_cnt,
`endif
    output logic                         busy
);

    localparam logic signed [BITWIDTH-1:0] MAX_V = BITWIDTH'(MAX_VAL);

    // Handshake: a beat moves on a side only in a cycle where valid & ready are both high;
    // a producer holding valid keeps its data stable until that cycle.
    logic                         s1_valid;
    logic [1:0]                   s1_mode;
    logic [CHANNELS*BITWIDTH-1:0] s1_data;
    logic                         s2_valid;
    logic [CHANNELS*BITWIDTH-1:0] s2_data;
    logic [CHANNELS*BITWIDTH-1:0] act_data;
    logic                         adv1;
    logic                         adv2;

    function automatic logic [BITWIDTH-1:0] activate(input logic [1:0] m,
                                                     input logic signed [BITWIDTH-1:0] x);
        logic [BITWIDTH-1:0] y;
        y = x;
        case (m)
            2'd1: if (x[BITWIDTH-1]) y = '0;
            2'd2: begin
                if (x[BITWIDTH-1])  y = '0;
                else if (x > MAX_V) y = MAX_V;
            end
            2'd3: if (x[BITWIDTH-1]) y = x >>> LEAKY_SHIFT;
            default: y = x;
        endcase
        return y;
    endfunction

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign act_data[k*BITWIDTH +: BITWIDTH] = activate(s1_mode, s1_data[k*BITWIDTH +: BITWIDTH]);
    end

    // S2 can take a beat when empty or draining this cycle; in_ready follows out_ready combinationally.
    assign adv2      = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | adv2;
    assign adv1      = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign busy      = s1_valid | s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 2'd0;
            s1_data  <= '0;
        end else if (adv1) begin
            s1_valid <= 1'b1;
            s1_mode  <= mode;
            s1_data  <= in_data;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            s2_data  <= act_data;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef RELU_CLIP_CNT_EN
    logic [CHANNELS-1:0] clip_flag;
    logic [CHANNELS-1:0] s2_clip;
    logic [16:0]         clip_sum;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_clip
        assign clip_flag[k] = (s1_mode == 2'd2) &&
                              ($signed(s1_data[k*BITWIDTH +: BITWIDTH]) > MAX_V);
    end

    always_comb begin
        clip_sum = {1'b0, clip_cnt};
        for (int k = 0; k < CHANNELS; k++) begin
            clip_sum = clip_sum + 17'(s2_clip[k]);
        end
    end

    // Flags travel with the beat so the count is taken when the beat leaves the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_clip  <= '0;
            clip_cnt <= 16'd0;
        end else begin
            if (adv2) s2_clip <= clip_flag;
            if (clip_clr)
                clip_cnt <= 16'd0;
            else if (s2_valid && out_ready)
                clip_cnt <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
        end
    end
`endif

endmodule
